// File: rtl/fetch_entry_buffer.sv
// Fetch entry buffer: first-word-fall-through FIFO from realigner to decode.
// Locks out pushes after an exception entry until the next flush.
module fetch_entry_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [VLEN-1:0]            addr_i,
  input  logic                       bp_taken_i,
  input  logic                       ex_valid_i,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [31:0]                fetch_entry_instr_o,
  output logic [VLEN-1:0]            fetch_entry_addr_o,
  output logic                       fetch_entry_bp_taken_o,
  output logic                       fetch_entry_ex_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0]     instr;
    logic [VLEN-1:0] addr;
    logic            bp_taken;
    logic            ex_valid;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ex_lock_q;
  logic          full;
  logic          push;
  logic          pop;
  entry_t        head;

  assign full          = (count_q == CW'(DEPTH));
  assign instr_ready_o = !full && !ex_lock_q && !flush_i;
  assign push          = instr_valid_i && instr_ready_o;

  assign fetch_entry_valid_o = (count_q != '0);
  assign pop = fetch_entry_valid_o && fetch_entry_ready_i;

  assign head                   = mem_q[rd_ptr_q];
  assign fetch_entry_instr_o    = head.instr;
  assign fetch_entry_addr_o     = head.addr;
  assign fetch_entry_bp_taken_o = head.bp_taken;
  assign fetch_entry_ex_valid_o = head.ex_valid;
  assign count_o                = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ex_lock_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      // storage is left stale; only control state is cleared
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ex_lock_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{instr:    instr_i,
                             addr:     addr_i,
                             bp_taken: bp_taken_i,
                             ex_valid: ex_valid_i};
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (ex_valid_i) begin
          ex_lock_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
